// File: rtl/bilateral_pkg.sv
// Shared types, default constants and the rounding multiply used by the
// time-multiplexed bilateral kernel multiplier.
package bilateral_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } bk_state_t;

    localparam int BK_K = 7;
    localparam int BK_W = 16;

    // Unsigned Q0.w rounding multiply: (a*b + 2^(w-1)) >> w, for w <= 32.
    // The result always fits in w bits, so callers may truncate safely.
    function automatic logic [31:0] bk_round_mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [63:0] full;
        full = ({32'd0, a} * {32'd0, b}) + (64'd1 << (w - 1));
        return 32'(full >> w);
    endfunction

endpackage

// File: rtl/bk_lane_mul.sv
// One multiplier lane: picks the operand pair for the current pass, forms the
// rounded product and registers it into the result slot owned by that pass.
// A lane owns SLOTS taps (lane, lane+LANES, lane+2*LANES, ...); for passes at
// or beyond SLOTS the lane has no tap and stays idle.
// With BILATERAL_KERNEL_SEQ_SUM_EN defined the live product is also exported
// so the top can accumulate the kernel sum.
module bk_lane_mul
    import bilateral_pkg::*;
#(
    parameter int W     = BK_W,
    parameter int SLOTS = 1,
    parameter int SELW  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SELW-1:0]     sel,
    input  logic [SLOTS*W-1:0]  a_slots,
    input  logic [SLOTS*W-1:0]  b_slots,
`ifdef BILATERAL_KERNEL_SEQ_SUM_EN
    output logic [W-1:0]        prod,
`endif
    output logic [SLOTS*W-1:0]  q
);

    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         active;

    // Operand select for the current pass; idle when the pass has no tap here.
    always_comb begin
        a      = '0;
        b      = '0;
        active = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (sel == SELW'(i)) begin
                a      = a_slots[i*W +: W];
                b      = b_slots[i*W +: W];
                active = en;
            end
        end
    end

    assign p = active ? W'(bk_round_mul(32'(a), 32'(b), W)) : '0;

`ifdef BILATERAL_KERNEL_SEQ_SUM_EN
    assign prod = p;
`endif

    // Register the product straight into the slot of the tap being processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (active && sel == SELW'(i)) begin
                    q[i*W +: W] <= p;
                end
            end
        end
    end

endmodule

// File: rtl/bilateral_kernel_seq.sv
// Time-multiplexed bilateral kernel multiplier: multiplies a KxK range kernel
// element-wise by a stored, runtime-writable space kernel using LANES
// rounding multipliers over P = ceil(K*K/LANES) passes.
// Optional feature macro: BILATERAL_KERNEL_SEQ_SUM_EN (adds out_sum, the sum of
// all output taps accumulated during the passes; otherwise out_sum is 0).
module bilateral_kernel_seq
    import bilateral_pkg::*;
#(
    parameter int K     = BK_K,
    parameter int W     = BK_W,
    parameter int LANES = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [K*K*W-1:0]             in_kernel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*W-1:0]             out_kernel,
    output logic [W+$clog2(K*K)-1:0]     out_sum,
    input  logic                         sk_wr_en,
    input  logic [$clog2(K*K)-1:0]       sk_wr_addr,
    input  logic [W-1:0]                 sk_wr_data,
    output logic                         sk_wr_ready
);

    localparam int N   = K * K;
    localparam int P   = (N + LANES - 1) / LANES;
    localparam int PCW = (P > 1) ? $clog2(P) : 1;
    localparam int SW  = W + $clog2(N);

    bk_state_t      state_reg;
    bk_state_t      state_next;
    logic [PCW-1:0] pass_reg;
    logic [N*W-1:0] in_reg;
    logic [W-1:0]   sk_reg [N];
    logic           handshake;
    logic           last_pass;
    logic           mul_en;

    assign handshake = in_valid && in_ready;
    assign last_pass = (pass_reg == PCW'(P - 1));
    assign mul_en    = (state_reg == MUL);

    // State register; reset aborts whatever operation is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state_reg;
        in_ready    = 1'b0;
        sk_wr_ready = 1'b0;
        out_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready    = 1'b1;
                sk_wr_ready = 1'b1;
                if (in_valid) state_next = MUL;
            end
            MUL: begin
                if (last_pass) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pass counter: restarts on each accepted kernel, parks on the last pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_reg <= '0;
        end else if (handshake) begin
            pass_reg <= '0;
        end else if (mul_en && !last_pass) begin
            pass_reg <= pass_reg + 1'b1;
        end
    end

    // Input register holds the range kernel for the whole multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_reg <= '0;
        end else if (handshake) begin
            in_reg <= in_kernel;
        end
    end

    // Space-kernel coefficients: full scale after reset, writable only in IDLE,
    // out-of-range addresses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) sk_reg[i] <= '1;
        end else if (sk_wr_en && sk_wr_ready && (32'(sk_wr_addr) < N)) begin
            sk_reg[sk_wr_addr] <= sk_wr_data;
        end
    end

`ifdef BILATERAL_KERNEL_SEQ_SUM_EN
    logic [W-1:0] lane_prod [LANES];
`endif

    // Lane gi handles taps gi, gi+LANES, ... ; slot gj of the lane is tap gj*LANES+gi.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam int SLOTS = (N - gi + LANES - 1) / LANES;
        logic [SLOTS*W-1:0] a_slots;
        logic [SLOTS*W-1:0] b_slots;
        logic [SLOTS*W-1:0] q;

        for (genvar gj = 0; gj < SLOTS; gj++) begin : g_slot
            assign a_slots[gj*W +: W] = in_reg[(gj*LANES+gi)*W +: W];
            assign b_slots[gj*W +: W] = sk_reg[gj*LANES+gi];
            assign out_kernel[(gj*LANES+gi)*W +: W] = q[gj*W +: W];
        end

        bk_lane_mul #(
            .W     (W),
            .SLOTS (SLOTS),
            .SELW  (PCW)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (mul_en),
            .sel     (pass_reg),
            .a_slots (a_slots),
            .b_slots (b_slots),
`ifdef BILATERAL_KERNEL_SEQ_SUM_EN
            .prod    (lane_prod[gi]),
`endif
            .q       (q)
        );
    end

`ifdef BILATERAL_KERNEL_SEQ_SUM_EN
    logic [SW-1:0] sum_reg;
    logic [SW-1:0] pass_sum;

    // Sum of this pass's lane products (idle lanes contribute zero).
    always_comb begin
        pass_sum = '0;
        for (int i = 0; i < LANES; i++) pass_sum = pass_sum + SW'(lane_prod[i]);
    end

    // Accumulator cleared on input handshake, grows by one pass per MUL cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (handshake) begin
            sum_reg <= '0;
        end else if (mul_en) begin
            sum_reg <= sum_reg + pass_sum;
        end
    end

    assign out_sum = sum_reg;
`else
    assign out_sum = '0;
`endif

endmodule

// File: doc/bilateral_kernel_seq.md
Name: bilateral_kernel_seq

Overview:
- Parametrised, time-multiplexed successor to the fixed 7x7 bilateral kernel multiplier.
- Accepts a KxK range kernel over a valid/ready handshake and multiplies it element-wise by an internally stored, runtime-programmable space kernel.
- Uses LANES fixed-point multipliers, reused over several cycles, instead of one multiplier per tap.
- Sits between the range-kernel generator and the filter convolution/normalisation stage.

Parameters:
- K, 7: kernel side length; N = K*K taps.
- W, 16: tap width, unsigned Q0.W fraction.
- LANES, 7: parallel multipliers, 1..N.
- P (localparam), ceil(N/LANES): number of multiply passes.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  range kernel valid.
- in_ready  out  1  block can accept a range kernel.
- in_kernel  in  N*W  range kernel; tap t at bits [t*W +: W], row-major.
- out_valid  out  1  bilateral kernel valid.
- out_ready  in  1  downstream accepts the kernel.
- out_kernel  out  N*W  bilateral kernel, same packing as in_kernel.
- out_sum  out  W+$clog2(N)  sum of out_kernel taps (only with the optional feature).
- sk_wr_en  in  1  space-kernel coefficient write strobe.
- sk_wr_addr  in  $clog2(N)  tap index.
- sk_wr_data  in  W  coefficient value.
- sk_wr_ready  out  1  coefficient write accepted this cycle.

Behaviour:
- FSM states IDLE, MUL, DONE. Reset state is IDLE.
- Reset values: out_valid=0, out_kernel=0, out_sum=0, pass counter=0, all space-kernel coefficients = 2^W-1.
- An rst_n assertion in any state aborts the current operation immediately; no partial output is produced.
- IDLE:
  - in_ready=1, sk_wr_ready=1.
  - When in_valid=1, latch in_kernel into an input register, clear the pass counter and go to MUL.
  - A coefficient write in the same cycle as an input handshake takes effect before MUL starts.
- MUL:
  - in_ready=0, sk_wr_ready=0. Coefficient writes are ignored and dropped.
  - On pass p, lanes l=0..LANES-1 process tap t = p*LANES + l.
  - Lanes with t >= N are idle and write nothing.
  - Product = (r*s + 2^(W-1)) >> W. This cannot overflow W bits, so no saturation is needed.
  - Each product is registered directly into out_kernel tap t.
  - After pass P-1 go to DONE.
- DONE:
  - out_valid=1; out_kernel and out_sum are held stable.
  - When out_ready=1, clear out_valid and go to IDLE.
- Latency: input handshake at cycle 0 gives out_valid=1 at cycle P+1. With defaults P=7, latency is 8.
- Throughput: one kernel per P+2 cycles when out_ready is held high.
- out_ready asserted outside DONE has no effect.
- in_valid outside IDLE is not acknowledged; the source must hold it.
- sk_wr_addr >= N: the write is ignored.
- LANES=N gives P=1 and a latency of 2 cycles.
- out_kernel contents are only defined while out_valid=1; downstream must not sample them in MUL.

Optional Feature:
- Macro: BILATERAL_KERNEL_SEQ_SUM_EN.
- Defined:
  - An accumulator of width W+$clog2(N) clears on the input handshake.
  - Each MUL pass adds that pass's active lane products.
  - out_sum carries the total in DONE, giving the normalisation denominator with no extra cycles.
- Undefined: no accumulator is built and out_sum is tied to 0.

Decomposition:
- Package bilateral_pkg holds:
  - the FSM state enum bk_state_t (IDLE, MUL, DONE);
  - default constants BK_K=7, BK_W=16;
  - the function bk_round_mul(a,b), which implements the rounding multiply.
- One natural sub-module, bk_lane_mul:
  - a single registered W x W fixed-point rounding multiplier with an enable input;
  - instantiated LANES times under a generate loop.

Test Plan:
- Reset, default coefficients, all range taps 2^16-1 -> out_kernel taps = 65534 each, out_valid at cycle 8, out_sum = 49*65534 = 3211166 (SUM_EN).
- Write coefficient 32768 to tap 24 and 0 to all others, then range tap 24 = 40000 -> tap 24 = 20000, all others 0, out_sum = 20000.
- out_ready held low for 10 cycles in DONE -> out_valid and data stay stable, in_ready=0, a second in_valid is not accepted until 1 cycle after the out_ready handshake.
- sk_wr_en during MUL with addr 0, data 0 -> sk_wr_ready=0, tap 0 output unchanged on both the current and the next kernel.
- rst_n pulsed low during MUL pass 3 -> out_valid=0, in_ready=1 after release, out_kernel=0, coefficients back to 2^W-1.
- Configuration K=5, LANES=4 (P=7, tap 24 in the last pass alone) -> tap 24 correct, latency 8, no write beyond tap 24.
